tt_uart_tx: RTL and testbench
=============================

Name: tt_uart_tx

Overview:
- Byte-stream transmitter for the outbound half of the tile's serial link. The project receives bytes on ui_in; this block sends response bytes back out on a uo_out pin.
- Accepts bytes over a valid/ready handshake into a small FIFO and serialises each one as 8N1 UART, LSB first.
- Instantiated inside tt_um_ashergitscrazy. Its tx output drives uo_out[0], and busy drives uo_out[1].

Parameters:
- CLK_DIV, 16, clk cycles per UART bit. Legal range is 2 or more. The bit counter width is $clog2(CLK_DIV).
- FIFO_DEPTH, 4, number of byte entries. Must be a power of 2, 2 or more.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  transmitter enable. When low, the transmitter FSM and bit counter freeze; the FIFO still accepts bytes.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a byte; equals (count < FIFO_DEPTH).
- tx  out  1  serial line, registered, idles high.
- busy  out  1  (state != IDLE) || (count != 0).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: tx=1, state=IDLE, count=0, bit counter=0, shift register=0. Therefore in_ready=1, busy=0, fifo_count=0.
- Reset mid-frame: tx=1 on the following edge; the frame is aborted and the FIFO is flushed.
- Push: a byte is written on any edge where in_valid && in_ready. in_data must be held while in_valid && !in_ready. A push with in_ready low is ignored.
- in_ready depends only on count. When full, in_ready stays 0 even in a cycle that also pops, so there is no push-through when full.
- Simultaneous push and pop when not full: count is unchanged, and both pointers advance mod FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. Each non-IDLE state holds for CLK_DIV enabled cycles, counted by bit_cnt from 0 to CLK_DIV-1.
  - IDLE: if ena && count>0, pop the head into the shift register, set tx<=0 and go to START.
  - START: tx=0. At the end of the bit, tx<=shift[0], bit_idx<=0 and go to DATA.
  - DATA: at each bit end, shift right and increment bit_idx. After bit 7, tx<=1 and go to STOP.
  - STOP: tx=1. At the end of the bit, if count>0, pop and go to START with tx<=0 (back-to-back, no idle gap). Otherwise go to IDLE.
- Latency: a push on edge E0 into an empty, idle block produces a tx falling edge at E1.
- Frame length is exactly 10*CLK_DIV cycles with ena=1.
- ena=0: state, bit_cnt, bit_idx, shift register and tx all hold their values, and no pop occurs. The current bit is stretched by the number of disabled cycles.
- All outputs are registered except in_ready and busy, which are combinational decodes of registered state.

Decomposition:
- Package tt_uart_pkg:
  - state enum (IDLE/START/DATA/STOP, 2 bits);
  - DATA_BITS=8;
  - STOP_BITS=1.
- Sub-module tt_sync_fifo (parameters WIDTH, DEPTH):
  - ports: push, pop, wdata, rdata, count;
  - rdata is the head entry, presented combinationally;
  - registered pointers with an extra-bit count.
- tt_uart_tx holds the FSM, bit counters and shift register, and instantiates tt_sync_fifo.

Test Plan:
- CLK_DIV=4: push 0x55 while idle. Expect tx low at E1, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then stop=1. tx returns to idle at E41, and busy falls at the same time.
- CLK_DIV=4: push 0xA5 then 0x3C on consecutive cycles. Expect two frames totalling 80 cycles with no high gap between the first stop bit and the second start bit. Decoded bytes are 0xA5 then 0x3C.
- ena=0, push 5 bytes on consecutive cycles. Expect the first 4 accepted, fifo_count=4, in_ready=0 on the 5th, and tx constant at 1. Raise ena: 4 frames are sent in order.
- Mid-DATA (bit 3 of 0xFF), assert rst for 1 cycle. Expect tx=1, fifo_count=0 and busy=0 on the next edge, and no further start bit.
- ena low for 3 cycles during bit 2 of 0x0F. Expect bit 2 to last CLK_DIV+3 cycles, with all other bits at CLK_DIV.
- FIFO at count=3 with a push in the same cycle as a pop. Expect count to stay 3 and byte order to be preserved.

Source files
------------

// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the tile's UART transmit path.
package tt_uart_pkg;

  // Transmitter frame phases; IDLE must stay encoded as zero.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Width of the data-bit index inside a frame.
  localparam int IDX_W = $clog2(DATA_BITS);

endpackage

// File: rtl/tt_sync_fifo.sv
// Small synchronous FIFO with head-of-queue read data presented combinationally.
// Handshake: a write happens on a rising edge where push is high and the FIFO
// is not full; a read happens where pop is high and the FIFO is not empty.
// Requests that cannot be honoured are ignored.
module tt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full blocks writes even when a pop happens in the same cycle.
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tt_uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; drives the tile's outbound serial pin.
// Handshake: in_data is taken on any rising edge where in_valid && in_ready;
// in_ready depends only on FIFO occupancy, and the sender must hold in_data
// stable while in_valid is high and in_ready is low.
module tt_uart_tx
  import tt_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output state_e                        dbg_state
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             pop;
  logic             push;
  logic [7:0]       head;
  logic             bit_end;
  logic             have_byte;

  assign in_ready  = fifo_count < FC_W'(FIFO_DEPTH);
  assign push      = in_valid && in_ready;
  assign have_byte = fifo_count != '0;
  assign bit_end   = bit_cnt_q == BIT_LAST;
  assign busy      = (state_q != IDLE) || have_byte;
  assign tx        = tx_q;
  assign dbg_state = state_q;

  tt_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .count (fifo_count)
  );

  // Frame state register; a reset aborts any frame and returns the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic: everything holds while ena is low, stretching the bit.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (have_byte) begin
            pop       = 1'b1;
            shift_d   = head;
            tx_d      = 1'b0;
            bit_cnt_d = '0;
            state_d   = START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt_d = '0;
            bit_idx_d = '0;
            tx_d      = shift_q[0];
            state_d   = DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt_d = '0;
            shift_d   = shift_q >> 1;
            if (bit_idx_q == IDX_LAST) begin
              tx_d    = 1'b1;
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx_q + IDX_W'(1);
              tx_d      = shift_q[1];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt_d = '0;
            if (have_byte) begin
              // Back-to-back frame: next start bit follows the stop bit directly.
              pop     = 1'b1;
              shift_d = head;
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_uart_tx.sv
// Directed bench for tt_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_tt_uart_tx;
  import tt_uart_pkg::*;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  state_e     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  tt_uart_tx #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Called at the sample just after the start-bit edge; returns one frame later.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * DIV; k++) begin
      check($sformatf("%s slot%0d tx", tag, k / DIV), {31'd0, tx}, {31'd0, frame[k / DIV]});
      check($sformatf("%s slot%0d busy", tag, k / DIV), {31'd0, busy}, 32'd1);
      tick();
    end
  endtask

  initial begin
    logic [9:0] f5;
    logic       saw_low;
    int         dur;

    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    check("rst tx", {31'd0, tx}, 32'd1);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick();

    // Single byte 0x55 from idle.
    in_data = 8'h55; in_valid = 1'b1;
    tick();                                        // after E0
    in_valid = 1'b0;
    check("t1 e0 tx", {31'd0, tx}, 32'd1);
    check("t1 e0 count", {29'd0, fifo_count}, 32'd1);
    check("t1 e0 busy", {31'd0, busy}, 32'd1);
    tick();                                        // after E1
    check("t1 e1 state", 32'(dbg_state), 32'(START));
    check("t1 e1 count", {29'd0, fifo_count}, 32'd0);
    expect_frame(8'h55, "t1");                     // ends after E41
    check("t1 e41 tx", {31'd0, tx}, 32'd1);
    check("t1 e41 busy", {31'd0, busy}, 32'd0);
    check("t1 e41 state", 32'(dbg_state), 32'(IDLE));
    tick();

    // Two bytes pushed back-to-back: frames must abut with no idle gap.
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    tick();                                        // start bit of 0xA5 begins here
    in_valid = 1'b0;
    check("t2 count", {29'd0, fifo_count}, 32'd1);
    expect_frame(8'hA5, "t2a");
    expect_frame(8'h3C, "t2b");
    check("t2 end tx", {31'd0, tx}, 32'd1);
    check("t2 end busy", {31'd0, busy}, 32'd0);
    tick();

    // Disabled transmitter: FIFO fills to 4 and rejects the 5th byte.
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h11 * (i + 1)); in_valid = 1'b1;
      tick();
      check($sformatf("t3 hold tx %0d", i), {31'd0, tx}, 32'd1);
    end
    check("t3 full count", {29'd0, fifo_count}, 32'd4);
    check("t3 full in_ready", {31'd0, in_ready}, 32'd0);
    check("t3 full busy", {31'd0, busy}, 32'd1);
    in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    check("t3 reject count", {29'd0, fifo_count}, 32'd4);
    check("t3 reject tx", {31'd0, tx}, 32'd1);
    ena = 1'b1;
    tick();
    check("t3 pop count", {29'd0, fifo_count}, 32'd3);
    expect_frame(8'h11, "t3a");
    expect_frame(8'h22, "t3b");
    expect_frame(8'h33, "t3c");
    expect_frame(8'h44, "t3d");
    check("t3 end tx", {31'd0, tx}, 32'd1);
    check("t3 end busy", {31'd0, busy}, 32'd0);
    check("t3 end count", {29'd0, fifo_count}, 32'd0);
    tick();

    // Push and pop in the same cycle at count=3.
    ena = 1'b0;
    in_data = 8'h66; in_valid = 1'b1;
    tick();
    in_data = 8'h77;
    tick();
    in_data = 8'h88;
    tick();
    check("t6 pre count", {29'd0, fifo_count}, 32'd3);
    ena = 1'b1; in_data = 8'h99;
    tick();
    in_valid = 1'b0;
    check("t6 same-cycle count", {29'd0, fifo_count}, 32'd3);
    check("t6 start tx", {31'd0, tx}, 32'd0);
    expect_frame(8'h66, "t6a");
    expect_frame(8'h77, "t6b");
    expect_frame(8'h88, "t6c");
    expect_frame(8'h99, "t6d");
    check("t6 end busy", {31'd0, busy}, 32'd0);
    tick();

    // ena low for 3 cycles inside data bit 2 of 0x0F.
    f5 = {1'b1, 8'h0F, 1'b0};
    in_data = 8'h0F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int s = 0; s < 10; s++) begin
      dur = (s == 3) ? DIV + 3 : DIV;
      for (int c = 0; c < dur; c++) begin
        if (s == 3 && c == 1) ena = 1'b0;
        if (s == 3 && c == 4) ena = 1'b1;
        check($sformatf("t5 slot%0d c%0d tx", s, c), {31'd0, tx}, {31'd0, f5[s]});
        tick();
      end
    end
    check("t5 end busy", {31'd0, busy}, 32'd0);
    check("t5 end state", 32'(dbg_state), 32'(IDLE));
    tick();

    // Reset in the middle of data bit 3 of 0xFF with another byte queued.
    in_data = 8'hFF; in_valid = 1'b1;
    tick();
    in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    repeat (17) tick();
    check("t4 mid tx", {31'd0, tx}, 32'd1);
    check("t4 mid state", 32'(dbg_state), 32'(DATA));
    check("t4 mid count", {29'd0, fifo_count}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4 rst tx", {31'd0, tx}, 32'd1);
    check("t4 rst count", {29'd0, fifo_count}, 32'd0);
    check("t4 rst busy", {31'd0, busy}, 32'd0);
    check("t4 rst in_ready", {31'd0, in_ready}, 32'd1);
    saw_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1) saw_low = 1'b1;
      tick();
    end
    check("t4 no start after rst", {31'd0, saw_low}, 32'd0);

    // Reset during a start bit must drive the line high on the next edge.
    in_data = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t7 start tx", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7 rst tx", {31'd0, tx}, 32'd1);
    check("t7 rst state", 32'(dbg_state), 32'(IDLE));
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
